seg7_scan_decoder: RTL and testbench
====================================

// Module: seg7_scan_decoder
// PURPOSE
//  Receive-side counterpart of the 4-digit scanned 7-segment driver. Watches the anode
//  select + segment bus, waits for each pattern to settle, decodes it back to a BCD digit
//  and rebuilds the 4-digit value. Used as on-board loopback/self-check of display logic.
// PARAMETERS
//  STABLE_CYCLES  4   identical consecutive samples needed before capture (>=2)
//  CNT_W          16  stability counter width; must hold STABLE_CYCLES-1
// PORTS
//  clk        in   1   system clock, all logic on rising edge
//  reset      in   1   asynchronous, active-low reset
//  am         in   4   anode select, active-low; bit i low = digit i driven
//  seg        in   8   segments, active-low; seg[7:1]=a..g, seg[0]=dp
//  digits     out  16  captured codes, digit i in [4i+3:4i]
//  dp         out  4   decimal point per digit, active-high (1 = lit)
//  valid      out  4   digit i captured since last frame_stb
//  digit_stb  out  1   1-cycle pulse per capture
//  frame_stb  out  1   1-cycle pulse when all 4 digits captured
//  seg_err    out  1   1-cycle pulse: captured pattern not in table
//  anode_err  out  1   1-cycle pulse: >1 anode low at capture point
//  err_sticky out  1   OR of all seg_err/anode_err since reset
// BEHAVIOUR
//  - Reset (reset=0, async): all outputs 0, internal sample regs 0, counter 0.
//  - am/seg are same-clock inputs; registered once (sample stage) before compare.
//  - Stability: new sample == previous sample -> counter+1 (saturates at STABLE_CYCLES-1).
//    Else counter=0. Capture event when counter steps to STABLE_CYCLES-1; one event per
//    settled window, none while saturated. digit_stb STABLE_CYCLES+1 clocks after am/seg
//    first hold steady.
//  - On capture event, by am value:
//    * exactly one bit low (index i): digits[i] <= code, dp[i] <= ~seg[0], valid[i] <= 1,
//      digit_stb=1. Re-capture of already-valid slot overwrites it.
//    * 4'hF (all off): ignored, no pulse.
//    * >1 bit low: anode_err=1, err_sticky=1, no digit/valid update.
//  - Decode table seg[7:1] -> code: 01->0 4F->1 12->2 06->3 4C->4 24->5 60->6 0D->7
//    00->8 04->9 7F->A (blank); any other -> F with seg_err=1, err_sticky=1 (still stored).
//  - Frame: if valid | (1<<i) == 4'hF after a capture, frame_stb=1 in same cycle as
//    digit_stb; valid clears to 0 on that edge; digits/dp keep last values.
//  - Changing pattern mid-window: counter restarts, nothing captured from partial window.
//  - Reset mid-frame: valid and partial digits lost; err_sticky cleared only by reset.
//  - Pulses are single-cycle, registered outputs; no combinational path input->output.
// TESTING
//  1 reset low with am=4'hE seg=8'h03 held -> all outputs 0; release -> digit_stb at
//    STABLE_CYCLES+1 clocks, digits[3:0]=0, valid=4'b0001.
//  2 scan am E,D,B,7 with seg 9F,25,0D,09 each held 6 clocks -> 4 digit_stb, frame_stb
//    on 4th, digits=16'h9321, valid=0 after frame.
//  3 hold am=E seg=03 for 20 clocks -> exactly one digit_stb.
//  4 am=E, seg toggles 03/9F every 2 clocks (STABLE_CYCLES=4) -> no digit_stb ever.
//  5 am=C seg=03 held -> anode_err pulse, err_sticky=1, valid unchanged.
//  6 am=B seg=8'hFE held -> digits[11:8]=F, dp[2]=1, seg_err pulse;
//    then am=B seg=8'hFF -> digits[11:8]=A, dp[2]=0.

Source files
------------

// File: rtl/seg7_scan_decoder.sv
// Receive side of a 4-digit scanned 7-segment bus: waits for each anode/segment pattern
// to settle, decodes it back to a digit code and rebuilds the 4-digit value.
module seg7_scan_decoder #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  am,
    input  logic [7:0]  seg,
    output logic [15:0] digits,
    output logic [3:0]  dp,
    output logic [3:0]  valid,
    output logic        digit_stb,
    output logic        frame_stb,
    output logic        seg_err,
    output logic        anode_err,
    output logic        err_sticky
);

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(STABLE_CYCLES - 1);

    logic [3:0]       am_s_q, am_p_q;
    logic [7:0]       seg_s_q, seg_p_q;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             same, capture;

    logic [15:0] digits_q, digits_d;
    logic [3:0]  dp_q, dp_d;
    logic [3:0]  valid_q, valid_d, valid_n;
    logic        digit_stb_q, digit_stb_d;
    logic        frame_stb_q, frame_stb_d;
    logic        seg_err_q, seg_err_d;
    logic        anode_err_q, anode_err_d;
    logic        err_sticky_q, err_sticky_d;

    logic [3:0] code;
    logic       code_bad;
    logic [3:0] sel;
    logic       single;

    // Stability tracking on the registered sample vs. the one before it.
    always_comb begin
        same    = (am_s_q == am_p_q) && (seg_s_q == seg_p_q);
        cnt_inc = cnt_q + 1'b1;
        capture = same && (cnt_q != CntMax) && (cnt_inc == CntMax);
        if (!same) begin
            cnt_d = '0;
        end else if (cnt_q == CntMax) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_inc;
        end
    end

    // Blank segments only decode to the blank code with the decimal point off as well;
    // a lone lit dp is not a pattern the driver produces, so it is flagged.
    always_comb begin
        code = 4'hF;
        case (seg_s_q[7:1])
            7'h01:   code = 4'h0;
            7'h4F:   code = 4'h1;
            7'h12:   code = 4'h2;
            7'h06:   code = 4'h3;
            7'h4C:   code = 4'h4;
            7'h24:   code = 4'h5;
            7'h60:   code = 4'h6;
            7'h0D:   code = 4'h7;
            7'h00:   code = 4'h8;
            7'h04:   code = 4'h9;
            7'h7F:   code = seg_s_q[0] ? 4'hA : 4'hF;
            default: code = 4'hF;
        endcase
        code_bad = (code == 4'hF);
    end

    always_comb begin
        sel          = ~am_s_q;
        single       = $onehot(sel);
        valid_n      = valid_q | sel;
        digits_d     = digits_q;
        dp_d         = dp_q;
        valid_d      = valid_q;
        digit_stb_d  = 1'b0;
        frame_stb_d  = 1'b0;
        seg_err_d    = 1'b0;
        anode_err_d  = 1'b0;
        err_sticky_d = err_sticky_q;
        if (capture) begin
            if (single) begin
                for (int i = 0; i < 4; i++) begin
                    if (sel[i]) begin
                        digits_d[4*i +: 4] = code;
                        dp_d[i]            = ~seg_s_q[0];
                    end
                end
                digit_stb_d  = 1'b1;
                seg_err_d    = code_bad;
                err_sticky_d = err_sticky_q | code_bad;
                if (valid_n == 4'hF) begin
                    frame_stb_d = 1'b1;
                    valid_d     = 4'h0;
                end else begin
                    valid_d = valid_n;
                end
            end else if (sel != 4'h0) begin
                anode_err_d  = 1'b1;
                err_sticky_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            am_s_q       <= '0;
            am_p_q       <= '0;
            seg_s_q      <= '0;
            seg_p_q      <= '0;
            cnt_q        <= '0;
            digits_q     <= '0;
            dp_q         <= '0;
            valid_q      <= '0;
            digit_stb_q  <= 1'b0;
            frame_stb_q  <= 1'b0;
            seg_err_q    <= 1'b0;
            anode_err_q  <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            am_s_q       <= am;
            am_p_q       <= am_s_q;
            seg_s_q      <= seg;
            seg_p_q      <= seg_s_q;
            cnt_q        <= cnt_d;
            digits_q     <= digits_d;
            dp_q         <= dp_d;
            valid_q      <= valid_d;
            digit_stb_q  <= digit_stb_d;
            frame_stb_q  <= frame_stb_d;
            seg_err_q    <= seg_err_d;
            anode_err_q  <= anode_err_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    assign digits     = digits_q;
    assign dp         = dp_q;
    assign valid      = valid_q;
    assign digit_stb  = digit_stb_q;
    assign frame_stb  = frame_stb_q;
    assign seg_err    = seg_err_q;
    assign anode_err  = anode_err_q;
    assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder: reset behaviour, a table of settled captures,
// and hand sequences for saturation, bouncing patterns and anode errors.
module tb_seg7_scan_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  am;
    logic [7:0]  seg;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  valid;
    logic        digit_stb, frame_stb, seg_err, anode_err, err_sticky;

    seg7_scan_decoder #(
        .STABLE_CYCLES(4),
        .CNT_W        (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .am        (am),
        .seg       (seg),
        .digits    (digits),
        .dp        (dp),
        .valid     (valid),
        .digit_stb (digit_stb),
        .frame_stb (frame_stb),
        .seg_err   (seg_err),
        .anode_err (anode_err),
        .err_sticky(err_sticky)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  am;
        logic [7:0]  seg;
        logic [15:0] exp_digits;
        logic [3:0]  exp_dp;
        logic [3:0]  exp_valid;
        int          exp_frame;
        int          exp_serr;
        logic        exp_sticky;
    } vec_t;

    vec_t vecs[12];

    int n_tests = 0;
    int n_fail  = 0;
    int c_stb, c_frame, c_serr, c_aerr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic clr_counts();
        c_stb = 0; c_frame = 0; c_serr = 0; c_aerr = 0;
    endtask

    // Drive a pattern for n clocks, counting pulses sampled 1 time unit after each edge.
    task automatic hold(input logic [3:0] a, input logic [7:0] s, input int n);
        am  = a;
        seg = s;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            c_stb   += int'(digit_stb);
            c_frame += int'(frame_stb);
            c_serr  += int'(seg_err);
            c_aerr  += int'(anode_err);
        end
    endtask

    task automatic do_reset(input logic [3:0] a, input logic [7:0] s);
        am    = a;
        seg   = s;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int first;

        //            am     seg    digits    dp      valid  frm serr sticky
        vecs[0]  = '{4'hE, 8'h9F, 16'h0001, 4'b0000, 4'b0001, 0, 0, 1'b0};
        vecs[1]  = '{4'hD, 8'h25, 16'h0021, 4'b0000, 4'b0011, 0, 0, 1'b0};
        vecs[2]  = '{4'hB, 8'h0D, 16'h0321, 4'b0000, 4'b0111, 0, 0, 1'b0};
        vecs[3]  = '{4'h7, 8'h09, 16'h9321, 4'b0000, 4'b0000, 1, 0, 1'b0};
        vecs[4]  = '{4'hE, 8'h98, 16'h9324, 4'b0001, 4'b0001, 0, 0, 1'b0};
        vecs[5]  = '{4'hD, 8'h49, 16'h9354, 4'b0001, 4'b0011, 0, 0, 1'b0};
        vecs[6]  = '{4'hB, 8'hC1, 16'h9654, 4'b0001, 4'b0111, 0, 0, 1'b0};
        vecs[7]  = '{4'h7, 8'h1A, 16'h7654, 4'b1001, 4'b0000, 1, 0, 1'b0};
        vecs[8]  = '{4'hE, 8'h01, 16'h7658, 4'b1000, 4'b0001, 0, 0, 1'b0};
        vecs[9]  = '{4'hB, 8'hFE, 16'h7F58, 4'b1100, 4'b0101, 0, 1, 1'b1};
        vecs[10] = '{4'hB, 8'hFF, 16'h7A58, 4'b1000, 4'b0101, 0, 0, 1'b1};
        vecs[11] = '{4'hD, 8'h6B, 16'h7AF8, 4'b1000, 4'b0111, 0, 1, 1'b1};

        // Reset held with a digit pattern present, then latency from release.
        do_reset(4'hE, 8'h03);
        chk("reset_digits", 32'(digits), 32'h0);
        chk("reset_dp_valid", 32'({dp, valid}), 32'h0);
        chk("reset_pulses", 32'({digit_stb, frame_stb, seg_err, anode_err, err_sticky}), 32'h0);
        reset = 1'b1;
        first = -1;
        clr_counts();
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            c_stb += int'(digit_stb);
            if (digit_stb && first < 0) first = k;
        end
        chk("latency_first_stb", 32'(first), 32'd5);
        chk("latency_stb_count", 32'(c_stb), 32'd1);
        chk("latency_digit0", 32'(digits[3:0]), 32'h0);
        chk("latency_valid", 32'(valid), 32'b0001);

        // Reset mid-frame, then the capture table.
        do_reset(4'hE, 8'h03);
        chk("midframe_reset_valid", 32'(valid), 32'h0);
        reset = 1'b1;
        for (int v = 0; v < 12; v++) begin
            clr_counts();
            hold(vecs[v].am, vecs[v].seg, 6);
            chk($sformatf("vec%0d_stb", v), 32'(c_stb), 32'd1);
            chk($sformatf("vec%0d_frame", v), 32'(c_frame), 32'(vecs[v].exp_frame));
            chk($sformatf("vec%0d_seg_err", v), 32'(c_serr), 32'(vecs[v].exp_serr));
            chk($sformatf("vec%0d_digits", v), 32'(digits), 32'(vecs[v].exp_digits));
            chk($sformatf("vec%0d_dp", v), 32'(dp), 32'(vecs[v].exp_dp));
            chk($sformatf("vec%0d_valid", v), 32'(valid), 32'(vecs[v].exp_valid));
            chk($sformatf("vec%0d_sticky", v), 32'(err_sticky), 32'(vecs[v].exp_sticky));
        end

        // Long hold captures exactly once.
        clr_counts();
        hold(4'hE, 8'h03, 20);
        chk("long_hold_stb", 32'(c_stb), 32'd1);
        chk("long_hold_digits", 32'(digits), 32'h7AF0);
        chk("long_hold_valid", 32'(valid), 32'b0111);

        // Pattern bouncing faster than the settle window never captures.
        clr_counts();
        for (int r = 0; r < 6; r++) begin
            hold(4'hE, 8'h9F, 2);
            hold(4'hE, 8'h03, 2);
        end
        chk("bounce_stb", 32'(c_stb), 32'd0);
        chk("bounce_digits", 32'(digits), 32'h7AF0);

        // All anodes off is ignored.
        clr_counts();
        hold(4'hF, 8'h25, 8);
        chk("blank_am_pulses", 32'(c_stb + c_aerr + c_serr), 32'd0);

        // Anode error after a fresh reset.
        do_reset(4'hE, 8'h03);
        chk("sticky_cleared", 32'(err_sticky), 32'd0);
        reset = 1'b1;
        clr_counts();
        hold(4'hE, 8'h03, 8);
        chk("pre_anode_valid", 32'(valid), 32'b0001);
        clr_counts();
        hold(4'hC, 8'h03, 8);
        chk("anode_err_count", 32'(c_aerr), 32'd1);
        chk("anode_err_no_stb", 32'(c_stb + c_serr), 32'd0);
        chk("anode_err_sticky", 32'(err_sticky), 32'd1);
        chk("anode_err_valid", 32'(valid), 32'b0001);
        chk("anode_err_digits", 32'(digits), 32'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
